// File: rtl/conv_pkg.sv
// Shared FSM state encoding and width helpers for the convolution engine.
package conv_pkg;

  typedef enum logic [2:0] {IDLE, MAC, FLUSH, OUT, DONE} state_t;

  function automatic int unsigned k_bits(input int unsigned maxk);
    return $clog2(maxk + 1);
  endfunction

  function automatic int unsigned x_addr_bits(input int unsigned rows, input int unsigned cols);
    return $clog2(rows * cols);
  endfunction

  function automatic int unsigned w_addr_bits(input int unsigned maxk);
    return $clog2(maxk * maxk);
  endfunction

endpackage

// File: rtl/conv_mac.sv
// Registered signed multiply-accumulate: load a sign-extended bias, or add a full-width product.
module conv_mac #(
  parameter int INW  = 24,
  parameter int OUTW = 56
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_load,
  input  logic signed [INW-1:0]  i_bias,
  input  logic                   i_en,
  input  logic signed [INW-1:0]  i_a,
  input  logic signed [INW-1:0]  i_b,
  output logic signed [OUTW-1:0] o_acc
);

  logic signed [2*INW-1:0] w_prod;
  logic signed [OUTW-1:0]  r_acc;

  assign w_prod = i_a * i_b;
  assign o_acc  = r_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_load) begin
      r_acc <= {{(OUTW-INW){i_bias[INW-1]}}, i_bias};
    end else if (i_en) begin
      r_acc <= r_acc + {{(OUTW-2*INW){w_prod[2*INW-1]}}, w_prod};
    end
  end

endmodule

// File: rtl/conv_engine.sv
// 2-D valid convolution of an R x C matrix with a KxK kernel plus bias, streamed out over AXI-Stream.
module conv_engine
  import conv_pkg::*;
#(
  parameter int INW  = 24,
  parameter int OUTW = 56,
  parameter int R    = 9,
  parameter int C    = 8,
  parameter int MAXK = 4,
  localparam int K_BITS      = k_bits(MAXK),
  localparam int X_ADDR_BITS = x_addr_bits(R, C),
  localparam int W_ADDR_BITS = w_addr_bits(MAXK)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   inputs_loaded,
  input  logic [K_BITS-1:0]      K,
  input  logic signed [INW-1:0]  B,
  output logic [X_ADDR_BITS-1:0] X_read_addr,
  input  logic signed [INW-1:0]  X_data,
  output logic [W_ADDR_BITS-1:0] W_read_addr,
  input  logic signed [INW-1:0]  W_data,
  output logic                   compute_finished,
  output logic signed [OUTW-1:0] OUT_AXIS_TDATA,
  output logic                   OUT_AXIS_TVALID,
  output logic                   OUT_AXIS_TLAST,
  input  logic                   OUT_AXIS_TREADY
);

  localparam int MINRC = (R < C) ? R : C;

  state_t                 r_state, w_state_nxt;
  logic [X_ADDR_BITS-1:0] r_r, r_c, w_r_nxt, w_c_nxt, w_r_last, w_c_last;
  logic [K_BITS-1:0]      r_i, r_j, w_i_nxt, w_j_nxt, w_km1;
  logic [X_ADDR_BITS-1:0] r_xaddr, w_xaddr_nxt;
  logic [W_ADDR_BITS-1:0] r_waddr, w_waddr_nxt;
  logic                   r_pend, r_armed;
  logic                   w_load, w_start, w_kbad, w_last;

  assign w_km1    = K - K_BITS'(1);
  assign w_r_last = X_ADDR_BITS'(R) - X_ADDR_BITS'(K);
  assign w_c_last = X_ADDR_BITS'(C) - X_ADDR_BITS'(K);
  assign w_kbad   = (K == '0) || (32'(K) > 32'(MINRC));
  assign w_start  = inputs_loaded && r_armed;
  assign w_last   = (r_r == w_r_last) && (r_c == w_c_last);

  always_comb begin
    w_state_nxt = r_state;
    w_r_nxt     = r_r;
    w_c_nxt     = r_c;
    w_i_nxt     = r_i;
    w_j_nxt     = r_j;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_r_nxt     = '0;
          w_c_nxt     = '0;
          w_i_nxt     = '0;
          w_j_nxt     = '0;
          w_load      = 1'b1;
          w_state_nxt = w_kbad ? DONE : MAC;
        end
      end
      MAC: begin
        if (r_j == w_km1) begin
          w_j_nxt = '0;
          if (r_i == w_km1) begin
            w_i_nxt     = '0;
            w_state_nxt = FLUSH;
          end else begin
            w_i_nxt = r_i + K_BITS'(1);
          end
        end else begin
          w_j_nxt = r_j + K_BITS'(1);
        end
      end
      FLUSH: w_state_nxt = OUT;
      OUT: begin
        if (OUT_AXIS_TREADY) begin
          if (w_last) begin
            w_state_nxt = DONE;
          end else begin
            w_load      = 1'b1;
            w_state_nxt = MAC;
            if (r_c == w_c_last) begin
              w_c_nxt = '0;
              w_r_nxt = r_r + X_ADDR_BITS'(1);
            end else begin
              w_c_nxt = r_c + X_ADDR_BITS'(1);
            end
          end
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Addresses are registered from next-state counters so each MAC cycle presents its own pair.
  assign w_xaddr_nxt = X_ADDR_BITS'((32'(w_r_nxt) + 32'(w_i_nxt)) * 32'(C) + 32'(w_c_nxt) + 32'(w_j_nxt));
  assign w_waddr_nxt = W_ADDR_BITS'(32'(w_i_nxt) * 32'(K) + 32'(w_j_nxt));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_r     <= '0;
      r_c     <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_xaddr <= '0;
      r_waddr <= '0;
      r_pend  <= 1'b0;
      r_armed <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_r     <= w_r_nxt;
      r_c     <= w_c_nxt;
      r_i     <= w_i_nxt;
      r_j     <= w_j_nxt;
      r_pend  <= (r_state == MAC);
      // A finished matrix disarms the start until inputs_loaded is seen low.
      if (!inputs_loaded) begin
        r_armed <= 1'b1;
      end else if (r_state == DONE) begin
        r_armed <= 1'b0;
      end
      if (w_state_nxt == MAC) begin
        r_xaddr <= w_xaddr_nxt;
        r_waddr <= w_waddr_nxt;
      end
    end
  end

  conv_mac #(
    .INW  (INW),
    .OUTW (OUTW)
  ) u_mac (
    .clk    (clk),
    .rst    (reset),
    .i_load (w_load),
    .i_bias (B),
    .i_en   (r_pend),
    .i_a    (X_data),
    .i_b    (W_data),
    .o_acc  (OUT_AXIS_TDATA)
  );

  assign X_read_addr      = r_xaddr;
  assign W_read_addr      = r_waddr;
  assign OUT_AXIS_TVALID  = (r_state == OUT);
  assign OUT_AXIS_TLAST   = (r_state == OUT) && w_last;
  assign compute_finished = (r_state == DONE);

endmodule

// File: tb/tb_conv_engine.sv
// Directed bench for conv_engine: three instances (3x3, 2x2, 4x4) sharing clock, reset and memories.
module tb_conv_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset, tready;
  logic               ld_a, ld_b, ld_c;
  logic [2:0]         K;
  logic signed [23:0] B;
  logic signed [23:0] xmem [16];
  logic signed [23:0] wmem [16];

  logic [3:0]         xa_a, wa_a, xa_c, wa_c, wa_b;
  logic [1:0]         xa_b;
  logic signed [23:0] xd_a, wd_a, xd_b, wd_b, xd_c, wd_c;
  logic signed [55:0] td_a, td_b, td_c;
  logic               tv_a, tv_b, tv_c, tl_a, tl_b, tl_c, fin_a, fin_b, fin_c;

  int n_assert = 0;
  int n_fail   = 0;

  always @(posedge clk) begin
    xd_a <= xmem[xa_a];
    wd_a <= wmem[wa_a];
    xd_b <= xmem[{2'b00, xa_b}];
    wd_b <= wmem[wa_b];
    xd_c <= xmem[xa_c];
    wd_c <= wmem[wa_c];
  end

  conv_engine #(.INW(24), .OUTW(56), .R(3), .C(3), .MAXK(4)) u_a (
    .clk(clk), .reset(reset), .inputs_loaded(ld_a), .K(K), .B(B),
    .X_read_addr(xa_a), .X_data(xd_a), .W_read_addr(wa_a), .W_data(wd_a),
    .compute_finished(fin_a), .OUT_AXIS_TDATA(td_a), .OUT_AXIS_TVALID(tv_a),
    .OUT_AXIS_TLAST(tl_a), .OUT_AXIS_TREADY(tready));

  conv_engine #(.INW(24), .OUTW(56), .R(2), .C(2), .MAXK(4)) u_b (
    .clk(clk), .reset(reset), .inputs_loaded(ld_b), .K(K), .B(B),
    .X_read_addr(xa_b), .X_data(xd_b), .W_read_addr(wa_b), .W_data(wd_b),
    .compute_finished(fin_b), .OUT_AXIS_TDATA(td_b), .OUT_AXIS_TVALID(tv_b),
    .OUT_AXIS_TLAST(tl_b), .OUT_AXIS_TREADY(tready));

  conv_engine #(.INW(24), .OUTW(56), .R(4), .C(4), .MAXK(4)) u_c (
    .clk(clk), .reset(reset), .inputs_loaded(ld_c), .K(K), .B(B),
    .X_read_addr(xa_c), .X_data(xd_c), .W_read_addr(wa_c), .W_data(wd_c),
    .compute_finished(fin_c), .OUT_AXIS_TDATA(td_c), .OUT_AXIS_TVALID(tv_c),
    .OUT_AXIS_TLAST(tl_c), .OUT_AXIS_TREADY(tready));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic vld(input int w);
    case (w)
      0:       return tv_a;
      1:       return tv_b;
      default: return tv_c;
    endcase
  endfunction

  // Counts clock edges until TVALID, bounded so a stuck DUT still reaches the summary.
  task automatic wait_v(input int w, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!vld(w) && n < 60);
  endtask

  int n;
  logic seen;
  logic signed [63:0] exp_a [3];
  logic signed [63:0] exp_b [4];

  initial begin
    exp_a = '{18, 22, 24};
    exp_b = '{-2, -4, -6, -8};
    reset = 1'b1; tready = 1'b1; ld_a = 1'b0; ld_b = 1'b0; ld_c = 1'b0;
    K = 3'd2; B = 24'sd10;
    for (int k = 0; k < 16; k++) begin
      xmem[k] = 24'(k + 1);
      wmem[k] = '0;
    end
    wmem[0] = 24'sd1;
    wmem[3] = 24'sd1;
    repeat (2) tick();
    chk("rst_tvalid", 64'(tv_a), 0);
    chk("rst_tdata", td_a, 0);
    chk("rst_tlast", 64'(tl_a), 0);
    chk("rst_fin", 64'(fin_a), 0);
    chk("rst_xaddr", 64'(xa_a), 0);
    chk("rst_waddr", 64'(wa_a), 0);
    reset = 1'b0;
    tick();

    // 3x3, K=2, identity kernel, bias 10: 16 18 22 24
    ld_a = 1'b1;
    tick(); chk("mac_x0", 64'(xa_a), 0); chk("mac_w0", 64'(wa_a), 0);
    tick(); chk("mac_x1", 64'(xa_a), 1); chk("mac_w1", 64'(wa_a), 1);
    tick(); chk("mac_x2", 64'(xa_a), 3); chk("mac_w2", 64'(wa_a), 2);
    tick(); chk("mac_x3", 64'(xa_a), 4); chk("mac_w3", 64'(wa_a), 3);
    wait_v(0, n);
    chk("lat_first", n + 4, 6);
    chk("y00", td_a, 16);
    chk("y00_tlast", 64'(tl_a), 0);
    for (int k = 0; k < 3; k++) begin
      wait_v(0, n);
      chk("period", n, 6);
      chk("y_stream", td_a, exp_a[k]);
      chk("y_tlast", 64'(tl_a), (k == 2) ? 1 : 0);
    end
    tick();
    chk("fin_pulse", 64'(fin_a), 1);
    chk("fin_tvalid", 64'(tv_a), 0);
    tick();
    chk("fin_one_cycle", 64'(fin_a), 0);

    // inputs_loaded still high after completion must not restart
    repeat (2) tick();
    ld_a = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      tick();
      seen = seen | tv_a | fin_a;
    end
    chk("no_restart", 64'(seen), 0);
    chk("addr_hold", 64'(xa_a), 8);

    // backpressure on the first result
    tready = 1'b0;
    ld_a = 1'b1;
    wait_v(0, n);
    chk("bp_lat", n, 6);
    chk("bp_y00", td_a, 16);
    repeat (5) begin
      tick();
      chk("bp_tvalid", 64'(tv_a), 1);
      chk("bp_tdata", td_a, 16);
    end
    tready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_v(0, n);
      chk("bp_stream", td_a, exp_a[k]);
    end
    tick();
    chk("bp_fin", 64'(fin_a), 1);
    ld_a = 1'b0;
    tick();

    // reset during MAC of the second result
    ld_a = 1'b1;
    wait_v(0, n);
    chk("rr_y00", td_a, 16);
    tick();
    tick();
    #1 reset = 1'b1;
    #1;
    chk("rr_tvalid", 64'(tv_a), 0);
    chk("rr_xaddr", 64'(xa_a), 0);
    chk("rr_acc", td_a, 0);
    tick();
    reset = 1'b0;
    wait_v(0, n);
    chk("rr_restart_lat", n, 6);
    chk("rr_restart_y00", td_a, 16);
    for (int k = 0; k < 3; k++) wait_v(0, n);
    chk("rr_last", td_a, 24);
    tick();
    chk("rr_fin", 64'(fin_a), 1);
    ld_a = 1'b0;
    tick();

    // illegal kernel sizes finish immediately
    K = 3'd0; ld_a = 1'b1;
    tick();
    chk("k0_done", 64'(fin_a), 1);
    chk("k0_tvalid", 64'(tv_a), 0);
    ld_a = 1'b0;
    tick();
    K = 3'd4; ld_a = 1'b1;
    tick();
    chk("kbig_done", 64'(fin_a), 1);
    ld_a = 1'b0;
    repeat (2) tick();

    // 2x2, K=1, W=-2: -2 -4 -6 -8
    K = 3'd1; B = '0; wmem[0] = -24'sd2;
    ld_b = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_v(1, n);
      chk("k1_lat", n, 3);
      chk("k1_y", td_b, exp_b[k]);
      chk("k1_tlast", 64'(tl_b), (k == 3) ? 1 : 0);
    end
    tick();
    chk("k1_fin", 64'(fin_b), 1);
    ld_b = 1'b0;
    tick();

    // 4x4, K=4, all operands at max positive: 16*(2^23-1)^2
    K = 3'd4;
    for (int k = 0; k < 16; k++) begin
      xmem[k] = 24'sh7FFFFF;
      wmem[k] = 24'sh7FFFFF;
    end
    ld_c = 1'b1;
    wait_v(2, n);
    chk("k4_lat", n, 18);
    chk("k4_y", td_c, 64'sd1125899638407184);
    chk("k4_tlast", 64'(tl_c), 1);
    tick();
    chk("k4_fin", 64'(fin_c), 1);
    ld_c = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_engine.md
CONV_ENGINE -- requirements
Module: conv_engine

Interface
REQ-001 SHALL have parameter INW, default 24: signed X/W/B word width.
REQ-002 SHALL have parameter OUTW, default 56: signed result width.
REQ-003 SHALL have parameters R, default 9, and C, default 8: X matrix rows and columns.
REQ-004 SHALL have parameter MAXK, default 4: largest kernel size; derived K_BITS=$clog2(MAXK+1), X_ADDR_BITS=$clog2(R*C), W_ADDR_BITS=$clog2(MAXK*MAXK).
REQ-005 SHALL have port clk, input, 1: single clock; reset is asynchronous and active-high.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port inputs_loaded, input, 1: X, W, K and B are valid and stable.
REQ-008 SHALL have port K, input, K_BITS: kernel size.
REQ-009 SHALL have port B, input, INW signed: bias.
REQ-010 SHALL have port X_read_addr, output, X_ADDR_BITS: X memory address.
REQ-011 SHALL have port X_data, input, INW signed: X memory data, valid one cycle after its address.
REQ-012 SHALL have port W_read_addr, output, W_ADDR_BITS: W memory address.
REQ-013 SHALL have port W_data, input, INW signed: W memory data, valid one cycle after its address.
REQ-014 SHALL have port compute_finished, output, 1: one-cycle pulse, all outputs accepted.
REQ-015 SHALL have port OUT_AXIS_TDATA, output, OUTW signed: result word.
REQ-016 SHALL have port OUT_AXIS_TVALID, output, 1: result valid.
REQ-017 SHALL have port OUT_AXIS_TLAST, output, 1: marks the final result of the matrix.
REQ-018 SHALL have port OUT_AXIS_TREADY, input, 1: downstream ready.

Function
REQ-019 SHALL compute Y[r][c] = B + sum over i,j in 0..K-1 of X[r+i][c+j]*W[i][j], for r in 0..R-K and c in 0..C-K.
REQ-020 SHALL emit results row-major: c varies fastest; (R-K+1)*(C-K+1) words per matrix.
REQ-021 SHALL drive X_read_addr=(r+i)*C+(c+j) and W_read_addr=i*K+j, with j innermost, then i.
REQ-022 SHALL form each INW x INW product at full 2*INW signed width, sign-extend B and products to OUTW, and accumulate modulo 2^OUTW with no saturation.
REQ-023 SHALL use FSM states: IDLE, MAC, FLUSH, OUT, DONE.
REQ-024 IDLE: TVALID=0; on a clock edge with inputs_loaded=1, clear r, c, i, j to 0, load the accumulator with B, and go to MAC; if K=0 or K>min(R,C), go to DONE instead.
REQ-025 MAC: one address pair per cycle for K*K cycles; the data returned in each cycle is multiplied and accumulated at the end of the following cycle; after the last address, go to FLUSH.
REQ-026 FLUSH: one cycle; the final product is accumulated; go to OUT.
REQ-027 OUT: TVALID=1; TDATA is the accumulator; TLAST=1 only for r=R-K, c=C-K.
REQ-028 OUT: TDATA and TLAST SHALL hold stable while TREADY=0.
REQ-029 OUT: on TVALID&&TREADY with more results, advance c, wrapping to 0 and incrementing r; reload the accumulator with B; go to MAC.
REQ-030 OUT: on TVALID&&TREADY after the last result, go to DONE.
REQ-031 DONE: compute_finished=1 for exactly one cycle; go to IDLE.
REQ-032 After DONE, SHALL NOT start a new matrix until inputs_loaded is sampled high again in IDLE.
REQ-033 Latency SHALL be K*K+2 cycles from MAC entry to TVALID.
REQ-034 Throughput SHALL be one result per K*K+2 cycles when TREADY is held at 1.
REQ-035 Address outputs SHALL hold their last value outside MAC; their value there is don't-care.
REQ-036 K and B SHALL be sampled continuously; they are stable for the whole time inputs_loaded=1.

Reset
REQ-037 reset=1 SHALL asynchronously force: state=IDLE, TVALID=0, TLAST=0, TDATA=0, compute_finished=0, addresses=0, all counters and the accumulator=0.
REQ-038 A reset asserted mid-matrix SHALL abandon the matrix; after release, the block waits in IDLE for inputs_loaded.

Structure
REQ-039 SHALL place the state enum typedef and the address-width localparams in shared package conv_pkg.
REQ-040 SHALL use a single sub-module, conv_mac: a registered signed multiply-accumulate with load-bias and accumulate-enable inputs.

Verification
REQ-041 R=3, C=3, K=2, X=1..9 row-major, W=[1,0;0,1], B=10, TREADY=1 -> outputs 16, 18, 22, 24; TLAST on 24; compute_finished one cycle after the 24 handshake.
REQ-042 Same data, TREADY=0 for 5 cycles during the first OUT -> TDATA holds 16 with TVALID=1 throughout; then 18, 22, 24 unchanged.
REQ-043 K=1, W=[-2], B=0, R=2, C=2, X=[1,2;3,4] -> outputs -2, -4, -6, -8; each 3 cycles after MAC entry.
REQ-044 K=MAXK=4, R=C=4, all X=W=2^(INW-1)-1, B=0 -> single output 16*(2^(INW-1)-1)^2; no overflow in OUTW=56.
REQ-045 Reset asserted during MAC of the second result -> TVALID=0 immediately; after release with inputs_loaded=1 the matrix restarts from result 16.
REQ-046 inputs_loaded held 1 for 3 cycles after the compute_finished pulse -> no spurious restart before inputs_loaded falls and rises again.
